axis_boxcar_decimator: RTL and testbench

AXIS_BOXCAR_DECIMATOR -- requirements
Module: axis_boxcar_decimator

---
 rtl/axis_boxcar_decimator.sv | 78 +++++++
 tb/tb_axis_boxcar_decimator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_boxcar_decimator.sv
// Boxcar decimator on AXI-Stream: sums (or picks the last of) each block of
// N = cfg_data+1 input samples and emits one full-width result per block.
module axis_boxcar_decimator #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic [CNTR_WIDTH-1:0]                  cfg_data,
    input  logic                                   cfg_mode,
    output logic                                   s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]            s_axis_tdata,
    input  logic                                   s_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic [AXIS_TDATA_WIDTH+CNTR_WIDTH-1:0] m_axis_tdata,
    output logic                                   m_axis_tvalid
);

    localparam int OUT_WIDTH = AXIS_TDATA_WIDTH + CNTR_WIDTH;

    logic [OUT_WIDTH-1:0]  acc_q, acc_d;
    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]  tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;

    logic                  in_beat;
    logic                  block_end;
    logic [OUT_WIDTH-1:0]  sample_ext;

    // Output register acts as a one-deep skid: accept input whenever it is empty or draining.
    assign s_axis_tready = ~tvalid_q | m_axis_tready;
    assign in_beat       = s_axis_tvalid & s_axis_tready;
    assign block_end     = (cnt_q >= cfg_data);
    assign sample_ext    = {{CNTR_WIDTH{s_axis_tdata[AXIS_TDATA_WIDTH-1]}}, s_axis_tdata};

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (in_beat) begin
            if (block_end) begin
                tdata_d  = cfg_mode ? sample_ext : (acc_q + sample_ext);
                tvalid_d = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = acc_q + sample_ext;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset is sampled on the clock edge.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

endmodule

// File: tb/tb_axis_boxcar_decimator.sv
// Self-checking bench for axis_boxcar_decimator: directed scenarios plus random
// traffic, scored against a block-list reference model.
module tb_axis_boxcar_decimator;

    localparam int W  = 16;
    localparam int C  = 16;
    localparam int OW = W + C;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [C-1:0]  cfg_data;
    logic          cfg_mode;
    logic          s_axis_tready;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          m_axis_tready;
    logic [OW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;

    axis_boxcar_decimator #(.AXIS_TDATA_WIDTH(W), .CNTR_WIDTH(C)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_data      (cfg_data),
        .cfg_mode      (cfg_mode),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: samples of the open block, and results owed to the output.
    longint blk_q[$];
    longint exp_q[$];
    longint got_q[$];
    bit     hold_valid;
    logic [OW-1:0] hold_data;
    bit     expect_valid;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_beat(input longint s, input int cfg, input bit md);
        longint sum;
        if (blk_q.size() >= cfg) begin
            sum = s;
            if (!md) foreach (blk_q[i]) sum += blk_q[i];
            exp_q.push_back(sum);
            blk_q.delete();
            expect_valid = 1'b1;
        end else begin
            blk_q.push_back(s);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 ns later, let the rising edge act.
    task automatic step(input bit v, input logic [W-1:0] d, input bit mr,
                        input logic [C-1:0] cfg, input bit md);
        bit in_beat, out_beat;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = mr;
        cfg_data      = cfg;
        cfg_mode      = md;
        #1;
        check("s_tready_rule", s_axis_tready, (!m_axis_tvalid) || mr);
        if (hold_valid) begin
            check("hold_valid", m_axis_tvalid, 1);
            check("hold_data", m_axis_tdata, hold_data);
        end
        if (expect_valid) check("latency_valid", m_axis_tvalid, 1);
        in_beat  = v && s_axis_tready;
        out_beat = m_axis_tvalid && mr;
        if (out_beat) begin
            got_q.push_back(longint'($signed(m_axis_tdata)));
            if (exp_q.size() == 0) check("unexpected_out", 1, 0);
            else check("out_data", longint'($signed(m_axis_tdata)), exp_q.pop_front());
        end
        hold_valid   = m_axis_tvalid && !mr;
        hold_data    = m_axis_tdata;
        expect_valid = 1'b0;
        if (in_beat) model_beat(longint'($signed(d)), int'(cfg), md);
        @(negedge aclk);
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge aclk);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tready", s_axis_tready, 1);
        aresetn = 1'b1;
        blk_q.delete();
        exp_q.delete();
        got_q.delete();
        hold_valid   = 1'b0;
        expect_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, cfg_data, cfg_mode);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0; cfg_data = '0; cfg_mode = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
        hold_valid = 1'b0; expect_valid = 1'b0; hold_data = '0;
        repeat (2) @(negedge aclk);
        check("init_tvalid", m_axis_tvalid, 0);
        check("init_tdata", m_axis_tdata, 0);
        check("init_tready", s_axis_tready, 1);

        // Sum of four, continuous.
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, C'(3), 1'b0);
        drain(3);
        check("sum4_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("sum4_first", got_q[0], 10);
            check("sum4_second", got_q[1], 26);
        end

        // Most negative inputs summed, full sign extension.
        do_reset();
        step(1'b1, 16'h8000, 1'b0, C'(1), 1'b0);
        step(1'b1, 16'h8000, 1'b0, C'(1), 1'b0);
        step(1'b0, '0, 1'b0, C'(1), 1'b0);
        check("neg_raw", m_axis_tdata, 32'hFFFF_0000);
        drain(2);
        if (got_q.size() == 1) check("neg_value", got_q[0], -65536);
        else check("neg_count", got_q.size(), 1);

        // Pass-through at N=1.
        do_reset();
        step(1'b1, 16'd5, 1'b1, C'(0), 1'b0);
        check("pass_tready0", s_axis_tready, 1);
        step(1'b1, 16'hFFFF, 1'b1, C'(0), 1'b0);
        check("pass_tready1", s_axis_tready, 1);
        step(1'b1, 16'd7, 1'b1, C'(0), 1'b0);
        check("pass_tready2", s_axis_tready, 1);
        step(1'b0, '0, 1'b1, C'(0), 1'b0);
        check("pass_count_3cycles", got_q.size(), 3);
        drain(1);
        if (got_q.size() == 3) begin
            check("pass_0", got_q[0], 5);
            check("pass_1", got_q[1], -1);
            check("pass_2", got_q[2], 7);
        end

        // Pick-last with downstream backpressure.
        do_reset();
        step(1'b1, 16'd9, 1'b0, C'(2), 1'b1);
        step(1'b1, 16'd8, 1'b0, C'(2), 1'b1);
        step(1'b1, 16'd7, 1'b0, C'(2), 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'd99, 1'b0, C'(2), 1'b1);
            check("bp_tready_low", s_axis_tready, 0);
            check("bp_tdata", longint'($signed(m_axis_tdata)), 7);
        end
        step(1'b1, 16'd99, 1'b1, C'(2), 1'b1);
        drain(2);
        check("bp_count", got_q.size(), 1);
        check("bp_partial_kept", blk_q.size(), 1);

        // Reset mid-block discards partial sum.
        do_reset();
        step(1'b1, 16'd100, 1'b1, C'(3), 1'b0);
        step(1'b1, 16'd100, 1'b1, C'(3), 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("rst_mid_no_out", m_axis_tvalid, 0);
            step(1'b1, 16'd1, 1'b1, C'(3), 1'b0);
        end
        drain(2);
        check("rst_mid_count", got_q.size(), 1);
        if (got_q.size() == 1) check("rst_mid_value", got_q[0], 4);

        // Ratio lowered below the running count.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 16'd1, 1'b1, C'(7), 1'b0);
        step(1'b1, 16'd1, 1'b1, C'(2), 1'b0);
        drain(2);
        check("cfg_drop_count", got_q.size(), 1);
        if (got_q.size() == 1) check("cfg_drop_value", got_q[0], 6);

        // Random traffic with ratio and mode changes.
        do_reset();
        begin
            logic [C-1:0] rc = C'(2);
            bit           rm = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 24) == 0) rc = C'($urandom_range(0, 5));
                if ($urandom_range(0, 30) == 0) rm = 1'($urandom_range(0, 1));
                step(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 3) != 0), rc, rm);
            end
            drain(4);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
